// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, pipelined imem requests,
// epoch-tagged instruction queue. Define FETCH_PREDECODE_EN for static JAL prediction.
module fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FQ_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          EPOCH_W         = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [31:0]        imem_req_addr,
    input  logic               imem_resp_valid,
    output logic               imem_resp_ready,
    input  logic [31:0]        imem_resp_inst,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_inst,
    output logic [EPOCH_W-1:0] out_epoch,
    output logic               out_pred_taken,
    output logic [31:0]        out_pred_target
);
    localparam int QAW = $clog2(FQ_DEPTH);
    localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = $clog2(FQ_DEPTH + 1) + 1;

    logic [31:0]        fetchPc_q, fetchPc_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic [CW-1:0]      tagCnt_q, tagCnt_d;
    logic [CW-1:0]      dropCnt_q, dropCnt_d;
    logic [QAW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [TAW-1:0]     tagRd_q, tagRd_d, tagWr_q, tagWr_d;

    logic [31:0]        tagMem_q      [MAX_OUTSTANDING];
    logic [31:0]        qPc_q         [FQ_DEPTH];
    logic [31:0]        qInst_q       [FQ_DEPTH];
    logic [EPOCH_W-1:0] qEpoch_q      [FQ_DEPTH];
    logic               qPredTaken_q  [FQ_DEPTH];
    logic [31:0]        qPredTarget_q [FQ_DEPTH];

    logic [CW-1:0] outstanding;
    logic          reqFire, respFire, respKeep, enqFire, deqFire, jalRedirect;
    logic [31:0]   respPc, predTarget;
    logic          predTaken;

    function automatic logic [TAW-1:0] nextTag(input logic [TAW-1:0] p);
        return (p == TAW'(MAX_OUTSTANDING - 1)) ? '0 : p + TAW'(1);
    endfunction

    // Space for every response is reserved when its request issues, so responses are always accepted.
    assign outstanding     = tagCnt_q + dropCnt_q;
    assign imem_req_valid  = !rst && !redirect_valid
                             && (outstanding < CW'(MAX_OUTSTANDING))
                             && ((occ_q + outstanding) < CW'(FQ_DEPTH));
    assign imem_req_addr   = fetchPc_q;
    assign imem_resp_ready = !rst;

    assign reqFire  = imem_req_valid && imem_req_ready;
    assign respFire = imem_resp_valid && !rst;
    assign respKeep = respFire && (dropCnt_q == '0);
    assign enqFire  = respKeep && !redirect_valid;
    assign deqFire  = out_valid && out_ready;
    assign respPc   = tagMem_q[tagRd_q];

`ifdef FETCH_PREDECODE_EN
    logic [31:0] jImm;
    always_comb begin
        jImm       = {{11{imem_resp_inst[31]}}, imem_resp_inst[31], imem_resp_inst[19:12],
                      imem_resp_inst[20], imem_resp_inst[30:21], 1'b0};
        predTaken  = (imem_resp_inst[6:0] == 7'b1101111);
        predTarget = predTaken ? (respPc + jImm) : (respPc + 32'd4);
    end
`else
    assign predTaken  = 1'b0;
    assign predTarget = respPc + 32'd4;
`endif

    assign jalRedirect = enqFire && predTaken;

    always_comb begin
        fetchPc_d = fetchPc_q;
        epoch_d   = epoch_q;
        occ_d     = occ_q;
        tagCnt_d  = tagCnt_q;
        dropCnt_d = dropCnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        tagRd_d   = tagRd_q;
        tagWr_d   = tagWr_q;

        if (reqFire) begin
            tagWr_d   = nextTag(tagWr_q);
            fetchPc_d = fetchPc_q + 32'd4;
        end
        if (respFire) begin
            if (dropCnt_q != '0) dropCnt_d = dropCnt_q - CW'(1);
            else                 tagRd_d   = nextTag(tagRd_q);
        end
        case ({reqFire, respKeep})
            2'b10:   tagCnt_d = tagCnt_q + CW'(1);
            2'b01:   tagCnt_d = tagCnt_q - CW'(1);
            default: ;
        endcase

        if (enqFire) tail_d = tail_q + QAW'(1);
        if (deqFire) head_d = head_q + QAW'(1);
        case ({enqFire, deqFire})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: ;
        endcase

        // Whatever is still in flight after this cycle belongs to the abandoned path.
        if (redirect_valid || jalRedirect) begin
            dropCnt_d = dropCnt_d + tagCnt_d;
            tagCnt_d  = '0;
            tagRd_d   = '0;
            tagWr_d   = '0;
            epoch_d   = epoch_q + EPOCH_W'(1);
            fetchPc_d = redirect_valid ? redirect_pc : predTarget;
        end
        if (redirect_valid) begin
            occ_d  = '0;
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q <= RESET_PC;
            epoch_q   <= '0;
            occ_q     <= '0;
            tagCnt_q  <= '0;
            dropCnt_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            tagRd_q   <= '0;
            tagWr_q   <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            epoch_q   <= epoch_d;
            occ_q     <= occ_d;
            tagCnt_q  <= tagCnt_d;
            dropCnt_q <= dropCnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            tagRd_q   <= tagRd_d;
            tagWr_q   <= tagWr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reqFire) tagMem_q[tagWr_q] <= fetchPc_q;
        if (enqFire) begin
            qPc_q[tail_q]         <= respPc;
            qInst_q[tail_q]       <= imem_resp_inst;
            qEpoch_q[tail_q]      <= epoch_q;
            qPredTaken_q[tail_q]  <= predTaken;
            qPredTarget_q[tail_q] <= predTarget;
        end
    end

    assign out_valid       = (occ_q != '0);
    assign out_pc          = out_valid ? qPc_q[head_q]         : '0;
    assign out_inst        = out_valid ? qInst_q[head_q]       : '0;
    assign out_epoch       = out_valid ? qEpoch_q[head_q]      : '0;
    assign out_pred_taken  = out_valid ? qPredTaken_q[head_q]  : 1'b0;
    assign out_pred_target = out_valid ? qPredTarget_q[head_q] : '0;

endmodule
